// File: rtl/mac_frame_accum_pkg.sv
// mac_acc_pkg: shared constants, FSM state type and max-tracker record for
// the MAC frame accumulator and its helper stages.
//
// Optional feature macro: MAC_ACC_MAX_TRACK_EN (max tracker record is always
// declared; only the accumulator decides whether to use it).
package mac_acc_pkg;

  localparam int DATA_W    = 17;  // width of one MAC result
  localparam int FRAME_LEN = 10;  // results per frame, 2..16
  localparam int SUM_W     = 21;  // DATA_W+4 holds 16 full-scale results
  localparam int IDX_W     = 4;   // beat index within a frame
  localparam int FRAME_W   = 8;   // frame sequence counter width

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] max_val;
    logic [IDX_W-1:0]  max_idx;
  } max_trk_t;

  // Strict greater-than keeps the first occurrence on ties; 'first' restarts
  // the tracker on the opening beat of a frame.
  function automatic max_trk_t max_trk_update(max_trk_t cur,
                                              logic [DATA_W-1:0] val,
                                              logic [IDX_W-1:0] idx,
                                              logic first);
    max_trk_t nxt;
    nxt = cur;
    if (first || (val > cur.max_val)) begin
      nxt.max_val = val;
      nxt.max_idx = idx;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mac_frame_accum_if.sv
// mac_frame_accum_if: input beat stream (valid/ready) and frame result
// (valid/ready) of the MAC frame accumulator.
//   master : producer of beats / consumer of results (upstream + sink)
//   slave  : the accumulator
// Optional feature macro: MAC_ACC_MAX_TRACK_EN adds out_max / out_max_idx.
interface mac_frame_accum_if;
  import mac_acc_pkg::*;

  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [SUM_W-1:0]    out_sum;
  logic [FRAME_W-1:0]  out_frame;
`ifdef MAC_ACC_MAX_TRACK_EN
  logic [DATA_W-1:0]   out_max;
  logic [IDX_W-1:0]    out_max_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_frame, out_max, out_max_idx
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_frame, out_max, out_max_idx
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_frame
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_frame
  );
`endif

endinterface

// File: rtl/mac_frame_accum_out_reg.sv
// mac_acc_out_reg: single-entry valid/ready holding register.
//   clk, reset : clock, async active-high reset (clears valid and data)
//   load       : capture load_data this cycle (wins over a drain)
//   load_data  : payload to capture
//   ready      : consumer takes the held payload when valid
//   valid/data : held payload
// The caller must only assert load when the register is empty or is being
// drained in the same cycle; the payload is stable while valid && !ready.
module mac_acc_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_frame_accum.sv
// mac_frame_accum: sums FRAME_LEN unsigned MAC results per frame and hands
// the sum plus an 8-bit wrapping frame number to a valid/ready output.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; drops any partial or pending frame
//   bus   : mac_frame_accum_if.slave (in_valid/in_data/in_ready,
//           out_valid/out_ready/out_sum/out_frame[/out_max/out_max_idx])
// Optional feature macro: MAC_ACC_MAX_TRACK_EN adds per-frame max value and
// its 0-based beat index, registered alongside the sum.
//
// state | meaning
// IDLE  | no beats of the current frame yet (idx=0, acc=0)
// ACCUM | 1..FRAME_LEN-1 beats collected, acc holds their sum
module mac_frame_accum
  import mac_acc_pkg::*;
(
  input logic               clk,
  input logic               reset,
  mac_frame_accum_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
`ifdef MAC_ACC_MAX_TRACK_EN
  localparam int PAY_W = DATA_W + IDX_W + FRAME_W + SUM_W;
`else
  localparam int PAY_W = FRAME_W + SUM_W;
`endif

  acc_state_e          state_q, state_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [SUM_W-1:0]    sum_next;
  logic                in_ready;
  logic                beat;
  logic                load;
  logic                out_valid;
  logic [PAY_W-1:0]    pay_d, pay_q;

  // Only the closing beat needs the output register, so only it can stall.
  assign in_ready = !((state_q == ACCUM) && (idx_q == LAST_IDX) &&
                      out_valid && !bus.out_ready);
  assign beat     = bus.in_valid && in_ready;
  assign sum_next = acc_q + SUM_W'(bus.in_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = SUM_W'(bus.in_data);
          idx_d   = IDX_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          if (idx_q == LAST_IDX) begin
            load    = 1'b1;
            frame_d = frame_q + FRAME_W'(1);
            acc_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = sum_next;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MAC_ACC_MAX_TRACK_EN
  max_trk_t trk_q, trk_next;

  assign trk_next = max_trk_update(trk_q, bus.in_data, idx_q, state_q == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_q <= '0;
    end else if (beat) begin
      trk_q <= trk_next;
    end
  end

  // The closing beat itself is folded in via trk_next.
  assign pay_d = {trk_next.max_val, trk_next.max_idx, frame_q, sum_next};
  assign {bus.out_max, bus.out_max_idx, bus.out_frame, bus.out_sum} = pay_q;
`else
  assign pay_d = {frame_q, sum_next};
  assign {bus.out_frame, bus.out_sum} = pay_q;
`endif

  mac_acc_out_reg #(.W(PAY_W)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (pay_d),
    .ready     (bus.out_ready),
    .valid     (out_valid),
    .data      (pay_q)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_mac_frame_accum.sv
// Bench for mac_frame_accum: directed frames from the test plan followed by
// randomized beats/gaps/out_ready, all compared every cycle against a
// frame-level reference model (list of beats, summed when the frame closes).
module tb_mac_frame_accum;
  import mac_acc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_frame_accum_if bus ();
  mac_frame_accum dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state.
  int unsigned m_beats[FRAME_LEN];
  int  m_cnt = 0;
  int  m_frame = 0;
  bit  m_v = 0;
  longint m_s = 0;
  int  m_f = 0;
  int  m_mx = 0;
  int  m_mi = 0;
  bit  m_acc = 0;

  typedef struct {
    longint s;
    int     f;
    int     mx;
    int     mi;
  } xfer_t;
  xfer_t xq[$];

  // Compare then advance the model, once per cycle on the falling edge.
  initial begin
    bit     rdy;
    bit     drained;
    longint s;
    int     mx, mi;
    xfer_t  x;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_cnt = 0; m_frame = 0; m_v = 0; m_s = 0; m_f = 0;
        m_mx = 0; m_mi = 0; m_acc = 0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_frame", bus.out_frame, 0);
`ifdef MAC_ACC_MAX_TRACK_EN
        chk("rst_out_max", bus.out_max, 0);
        chk("rst_out_max_idx", bus.out_max_idx, 0);
`endif
      end else begin
        rdy = !((m_cnt == FRAME_LEN - 1) && m_v && !bus.out_ready);
        chk("in_ready", bus.in_ready, rdy);
        chk("out_valid", bus.out_valid, m_v);
        if (m_v) begin
          chk("out_sum", bus.out_sum, m_s);
          chk("out_frame", bus.out_frame, m_f);
`ifdef MAC_ACC_MAX_TRACK_EN
          chk("out_max", bus.out_max, m_mx);
          chk("out_max_idx", bus.out_max_idx, m_mi);
`endif
        end
        if (bus.out_valid && bus.out_ready) begin
          x.s = bus.out_sum;
          x.f = bus.out_frame;
          x.mx = 0;
          x.mi = 0;
`ifdef MAC_ACC_MAX_TRACK_EN
          x.mx = bus.out_max;
          x.mi = bus.out_max_idx;
`endif
          xq.push_back(x);
        end
        m_acc = bus.in_valid && rdy;
        drained = m_v && bus.out_ready;
        if (m_acc) begin
          m_beats[m_cnt] = bus.in_data;
          m_cnt++;
        end
        if (m_acc && m_cnt == FRAME_LEN) begin
          s = 0; mx = 0; mi = 0;
          for (int i = 0; i < FRAME_LEN; i++) begin
            s += m_beats[i];
            if (i == 0 || m_beats[i] > mx) begin
              mx = m_beats[i];
              mi = i;
            end
          end
          m_v = 1; m_s = s; m_f = m_frame; m_mx = mx; m_mi = mi;
          m_frame = (m_frame + 1) % 256;
          m_cnt = 0;
        end else if (drained) begin
          m_v = 0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // All drive points are 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    forever begin
      @(posedge clk);
      if (m_acc) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_data = DATA_W'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    xq.delete();
  endtask

  task automatic exp_xfer(input string nm, input int k, input longint s, input int f);
    if (k < xq.size()) begin
      chk({nm, "_sum"}, xq[k].s, s);
      chk({nm, "_frame"}, xq[k].f, f);
    end else begin
      chk({nm, "_missing"}, xq.size(), k + 1);
    end
  endtask

  bit rnd_done = 0;
  int unsigned vals[FRAME_LEN] = '{5, 9, 2, 9, 0, 0, 0, 0, 0, 1};

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    xq.delete();

    // 10 x 65280 back-to-back
    repeat (FRAME_LEN) send(17'd65280);
    idle(3);
    chk("t1_count", xq.size(), 1);
    exp_xfer("t1", 0, 652800, 0);

    // 1..10 with a gap after beat 4
    xq.delete();
    for (int v = 1; v <= FRAME_LEN; v++) begin
      send(DATA_W'(v));
      if (v == 4) idle(3);
    end
    idle(3);
    chk("t2_count", xq.size(), 1);
    exp_xfer("t2", 0, 55, 1);

    // backpressure: frame 0 held, frame 1 stalls on its closing beat
    do_reset();
    bus.out_ready = 1'b0;
    repeat (2 * FRAME_LEN - 1) send(17'd1);
    bus.in_valid = 1'b1;
    bus.in_data = 17'd1;
    idle(3);
    chk("t3_stall_in_ready", bus.in_ready, 0);
    chk("t3_held_valid", bus.out_valid, 1);
    chk("t3_held_sum", bus.out_sum, 10);
    chk("t3_held_frame", bus.out_frame, 0);
    bus.out_ready = 1'b1;
    send(17'd1);
    idle(3);
    chk("t3_count", xq.size(), 2);
    exp_xfer("t3a", 0, 10, 0);
    exp_xfer("t3b", 1, 10, 1);

    // reset mid-frame discards the partial frame
    do_reset();
    repeat (6) send(17'd7);
    do_reset();
    repeat (FRAME_LEN) send(17'd3);
    idle(3);
    chk("t4_count", xq.size(), 1);
    exp_xfer("t4", 0, 30, 0);

    // frame counter wrap
    do_reset();
    repeat (257 * FRAME_LEN) send(17'd0);
    idle(3);
    chk("t5_count", xq.size(), 257);
    exp_xfer("t5_255", 255, 0, 255);
    exp_xfer("t5_256", 256, 0, 0);

    // max tracker frame (sum checked in every build)
    do_reset();
    for (int i = 0; i < FRAME_LEN; i++) send(DATA_W'(vals[i]));
    idle(3);
    exp_xfer("t6", 0, 26, 0);
`ifdef MAC_ACC_MAX_TRACK_EN
    if (xq.size() > 0) begin
      chk("t6_max", xq[0].mx, 9);
      chk("t6_max_idx", xq[0].mi, 1);
    end else begin
      chk("t6_max_missing", xq.size(), 1);
    end
`endif

    // randomized traffic with random out_ready
    do_reset();
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    for (int f = 0; f < 40; f++) begin
      for (int b = 0; b < FRAME_LEN; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) send(DATA_W'($urandom_range(0, 3)));
        else send(DATA_W'($urandom));
      end
    end
    rnd_done = 1;
    idle(2);
    bus.out_ready = 1'b1;
    idle(5);
    chk("t7_count", xq.size(), 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
